arts_div_n16_ss2_seq: RTL and testbench



---
 rtl/arts_div_n16_ss2_seq.sv | 146 ++++++++++++++
 tb/tb_arts_div_n16_ss2_seq.sv | 169 ++++++++++++++++
 2 files changed

// File: rtl/arts_div_n16_ss2_seq.sv
// Approximate unsigned 16/16 divider: 4-bit leading-segment operands, restoring divide, rescale by segment-index difference.
// Latency: operands accepted at edge E -> out_valid after edge E+22 (20 DIV + NORM + DONE settle); one operation in flight.
// Backpressure: holds Q/dz/out_valid in DONE until out_ready; in_ready only in IDLE. Optional rounding: define ARTS_DIV_ROUND_EN.
module arts_div_n16_ss2_seq (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [15:0] A,
  input  logic [15:0] B,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [15:0] Q,
  output logic        dz
);

  typedef enum logic [1:0] {IDLE, DIV, NORM, DONE} state_t;

  state_t      state, state_nxt;

  logic [3:0]  ta_r, tb_r;
  logic [2:0]  ka_r, kb_r;
  logic        bz_r;
  logic [3:0]  rem_r;
  logic [19:0] nq_r;      // dividend bits shift out of the top, quotient bits shift in at the bottom
  logic [4:0]  cnt_r;

  logic [6:0]  seg_a, seg_b;
  logic [4:0]  rem_sh, trial;
  logic        qbit;
  logic [5:0]  s_c;
  logic [19:0] shifted;
  logic        rbit;
  logic [20:0] qsum;
  logic [15:0] q_norm;

  // Returns {K, XH, XL}: index of the highest nonzero 2-bit segment and the 4-bit leading approximation.
  function automatic logic [6:0] seg_detect(input logic [15:0] x);
    logic [2:0] k;
    logic [1:0] xh, xl;
    logic [3:0] lo_idx;
    k = 3'd0;
    for (int i = 0; i < 8; i++) begin
      if (x[2*i +: 2] != 2'b00) k = 3'(i);
    end
    xh     = x[{k, 1'b0} +: 2];
    lo_idx = {k, 1'b0} - 4'd2;   // wraps harmlessly when k==0; masked below
    xl     = (k == 3'd0) ? 2'b00 : x[lo_idx +: 2];
    return {k, xh, xl};
  endfunction

  // Segment detect on the live inputs, sampled only at the accept edge.
  always_comb begin
    seg_a = seg_detect(A);
    seg_b = seg_detect(B);
  end

  // One restoring-division step: shift in the next dividend bit, trial-subtract the divisor.
  always_comb begin
    rem_sh = {rem_r, nq_r[19]};
    trial  = rem_sh - {1'b0, tb_r};
    qbit   = (rem_sh >= {1'b0, tb_r});
  end

  // Normalize: Q = R >> (16 - 2*(Ka-Kb)); shifts past the register width naturally give 0.
  always_comb begin
    s_c     = 6'd16 + {2'b00, kb_r, 1'b0} - {2'b00, ka_r, 1'b0};
    shifted = nq_r >> s_c;
    rbit    = 1'b0;
`ifdef ARTS_DIV_ROUND_EN
    rbit    = nq_r[0] & 1'b0;
    if (s_c <= 6'd20) rbit = nq_r[5'(s_c - 6'd1)];
`endif
    qsum    = {1'b0, shifted} + {20'd0, rbit};
    q_norm  = (|qsum[20:16]) ? 16'hFFFF : qsum[15:0];
  end

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Next-state decode; in_ready comes straight from the state register.
  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    case (state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) state_nxt = DIV;
      end
      DIV:  if (cnt_r == 5'd0) state_nxt = NORM;
      NORM: state_nxt = DONE;
      DONE: if (out_valid && out_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Datapath and registered outputs; out_valid rises on the first DONE edge so latency is 22.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ta_r      <= 4'd0;
      tb_r      <= 4'd0;
      ka_r      <= 3'd0;
      kb_r      <= 3'd0;
      bz_r      <= 1'b0;
      rem_r     <= 4'd0;
      nq_r      <= 20'd0;
      cnt_r     <= 5'd0;
      Q         <= 16'h0000;
      dz        <= 1'b0;
      out_valid <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            ka_r  <= seg_a[6:4];
            ta_r  <= seg_a[3:0];
            kb_r  <= seg_b[6:4];
            tb_r  <= seg_b[3:0];
            bz_r  <= (B == 16'h0000);
            rem_r <= 4'd0;
            nq_r  <= {seg_a[3:0], 16'h0000};
            cnt_r <= 5'd19;
          end
        end
        DIV: begin
          // With a zero divisor every trial succeeds; that result is overridden in NORM.
          rem_r <= qbit ? trial[3:0] : rem_sh[3:0];
          nq_r  <= {nq_r[18:0], qbit};
          cnt_r <= cnt_r - 5'd1;
        end
        NORM: begin
          Q  <= bz_r ? 16'hFFFF : q_norm;
          dz <= bz_r;
        end
        DONE: begin
          out_valid <= !(out_valid && out_ready);
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_arts_div_n16_ss2_seq.sv
// Bench for arts_div_n16_ss2_seq: directed cases, randomized operands, backpressure and mid-operation reset.
// Reference is plain integer arithmetic on the segment approximations; latency and handshake checked per operation.
// Inputs driven and outputs sampled on the falling edge.
module tb_arts_div_n16_ss2_seq;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] A, B;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] Q;
  logic        dz;

  int n_vec = 0;
  int n_err = 0;

  arts_div_n16_ss2_seq dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .A(A), .B(B), .out_valid(out_valid), .out_ready(out_ready), .Q(Q), .dz(dz)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
    end
  endtask

  // Leading-segment approximation: x ~= t * 4^(k-1).
  function automatic void approx(input int x, output int k, output int t);
    k = 0;
    for (int i = 0; i < 8; i++) if (((x >> (2 * i)) & 3) != 0) k = i;
    t = ((x >> (2 * k)) & 3) * 4;
    if (k > 0) t = t + ((x >> (2 * k - 2)) & 3);
  endfunction

  function automatic void model(input logic [15:0] a, input logic [15:0] b,
                                output logic [15:0] q, output logic z);
    int ka, kb, ta, tb, s;
    longint r, qq;
    approx(int'(a), ka, ta);
    approx(int'(b), kb, tb);
    if (b == 16'd0) begin
      q = 16'hFFFF;
      z = 1'b1;
    end else begin
      r  = (longint'(ta) * 65536) / tb;
      s  = 16 - 2 * (ka - kb);
      qq = (s >= 20) ? 0 : (r >> s);
`ifdef ARTS_DIV_ROUND_EN
      if (s - 1 < 20) qq = qq + ((r >> (s - 1)) & 1);
`endif
      if (qq > 65535) qq = 65535;
      q = 16'(qq);
      z = 1'b0;
    end
  endfunction

  // One full transaction; caller is at a falling edge with the block idle.
  task automatic run_op(input logic [15:0] a, input logic [15:0] b, input int hold,
                        output logic [15:0] q_obs);
    logic [15:0] eq;
    logic        edz;
    int          t, lat;
    model(a, b, eq, edz);
    t = 0;
    while (in_ready !== 1'b1 && t < 50) begin @(negedge clk); t++; end
    check("in_ready_idle", {31'd0, in_ready}, 32'd1);
    A = a; B = b; in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0; A = 16'($urandom); B = 16'($urandom);
    check("in_ready_busy", {31'd0, in_ready}, 32'd0);
    lat = 0;
    while (out_valid !== 1'b1 && lat < 60) begin @(negedge clk); lat++; end
    check("latency", lat, 22);
    check("q", {16'd0, Q}, {16'd0, eq});
    check("dz", {31'd0, dz}, {31'd0, edz});
    q_obs = Q;
    for (int i = 0; i < hold; i++) begin
      in_valid = i[0]; A = 16'($urandom); B = 16'($urandom);
      @(negedge clk);
      check("hold_q", {16'd0, Q}, {16'd0, eq});
      check("hold_dz", {31'd0, dz}, {31'd0, edz});
      check("hold_vld", {31'd0, out_valid}, 32'd1);
      check("hold_rdy", {31'd0, in_ready}, 32'd0);
    end
    in_valid = 1'b0; out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    check("vld_drop", {31'd0, out_valid}, 32'd0);
    check("rdy_back", {31'd0, in_ready}, 32'd1);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL timeout: simulation did not complete, expected finish");
    $fatal(1);
  end

  initial begin
    logic [15:0] q;
    logic [15:0] ra, rb;
    int          seen;
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; A = 16'd0; B = 16'd0;
    #12;
    check("rst_in_ready", {31'd0, in_ready}, 32'd1);
    check("rst_out_valid", {31'd0, out_valid}, 32'd0);
    check("rst_q", {16'd0, Q}, 32'd0);
    check("rst_dz", {31'd0, dz}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    run_op(16'h0100, 16'h0010, 0, q);
    check("tp_exact", {16'd0, q}, 32'd16);
    run_op(16'hFFFF, 16'h0001, 0, q);
    check("tp_max", {16'd0, q}, 32'hF000);
    run_op(16'h0007, 16'h0002, 0, q);
`ifdef ARTS_DIV_ROUND_EN
    check("tp_round", {16'd0, q}, 32'd4);
`else
    check("tp_trunc", {16'd0, q}, 32'd3);
`endif
    run_op(16'h1234, 16'h0000, 0, q);
    check("tp_divzero", {16'd0, q}, 32'hFFFF);
    run_op(16'h0000, 16'h0005, 0, q);
    check("tp_zero_num", {16'd0, q}, 32'd0);
    run_op(16'h8000, 16'h0003, 10, q);

    for (int n = 0; n < 40; n++) begin
      ra = 16'($urandom) >> $urandom_range(0, 15);
      rb = 16'($urandom) >> $urandom_range(0, 15);
      if ($urandom_range(0, 9) == 0) rb = 16'd0;
      run_op(ra, rb, $urandom_range(0, 3), q);
    end

    // Leave a nonzero Q behind, then abort an operation mid-divide.
    run_op(16'hFFFF, 16'h0001, 0, q);
    A = 16'h4321; B = 16'h0077; in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    repeat (10) @(negedge clk);
    rst = 1'b1;
    #1;
    check("abort_out_valid", {31'd0, out_valid}, 32'd0);
    check("abort_q", {16'd0, Q}, 32'd0);
    check("abort_dz", {31'd0, dz}, 32'd0);
    check("abort_in_ready", {31'd0, in_ready}, 32'd1);
    @(negedge clk);
    rst = 1'b0;
    seen = 0;
    repeat (30) begin
      @(negedge clk);
      if (out_valid === 1'b1) seen++;
    end
    check("abort_no_valid", seen, 0);
    run_op(16'h0001, 16'hFFFF, 0, q);
    check("tp_after_rst", {16'd0, q}, 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
